// File: rtl/pll_mdrp_pkg.sv
// rtl/pll_mdrp_pkg.sv - shared types, MDRP opcodes and per-mode register tables
package pll_mdrp_pkg;

   typedef enum logic [3:0] {
      IDLE,
      PTR_RST,
      SEEK,
      WRITE,
      READ,
      VERIFY,
      NEXT,
      FIN_RST,
      WAIT_LOCK,
      DONE
   } state_e;

   localparam logic [1:0] OPC_NOP   = 2'b00;
   localparam logic [1:0] OPC_WRITE = 2'b01;
   localparam logic [1:0] OPC_READ  = 2'b10;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } mdrp_entry_t;

   // Mode 0 = PAL (141.8 MHz), mode 1 = NTSC (143.2 MHz); addresses ascend within a mode
   function automatic mdrp_entry_t tbl_entry(input logic m, input logic [2:0] idx);
      mdrp_entry_t e;
      if (m) begin
         case (idx)
            3'd0: e = {8'h05, 8'h35};
            3'd1: e = {8'h07, 8'h02};
            3'd2: e = {8'h08, 8'h1F};
            3'd3: e = {8'h09, 8'h00};
            3'd4: e = {8'h0A, 8'h3F};
            3'd5: e = {8'h0B, 8'h80};
            3'd6: e = {8'h0C, 8'h14};
            default: e = {8'h0D, 8'h07};
         endcase
      end else begin
         case (idx)
            3'd0: e = {8'h04, 8'h2C};
            3'd1: e = {8'h06, 8'hA1};
            3'd2: e = {8'h08, 8'h1E};
            3'd3: e = {8'h09, 8'h00};
            3'd4: e = {8'h0A, 8'h3F};
            3'd5: e = {8'h0B, 8'h80};
            3'd6: e = {8'h0C, 8'h12};
            default: e = {8'h0D, 8'h07};
         endcase
      end
      return e;
   endfunction

endpackage

// File: rtl/pll_mdrp_seq.sv
// rtl/pll_mdrp_seq.sv - shared counter for reset pulse width and lock timeout
module pll_mdrp_seq #(
   parameter int RST_CYC      = 4,
   parameter int LOCK_TIMEOUT = 65535
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   output logic rst_hit,
   output logic to_hit
);

   localparam int CW = 17;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Count while the controller dwells in a timed state, otherwise restart from zero
   always_comb begin
      cnt_d = '0;
      if (run) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign rst_hit = (cnt_q == CW'(RST_CYC - 1));
   assign to_hit  = (cnt_q == CW'(LOCK_TIMEOUT - 1));

endmodule

// File: rtl/pll_mdrp_ctrl.sv
// rtl/pll_mdrp_ctrl.sv - PLL MDRP reconfiguration sequencer (seek, write, verify, relock)
module pll_mdrp_ctrl
   import pll_mdrp_pkg::*;
#(
   parameter int NUM_ENTRIES  = 2,
   parameter int RST_CYC      = 4,
   parameter int LOCK_TIMEOUT = 65535
) (
   input  logic       mdclk,
   input  logic       reset,
   input  logic       req,
   input  logic       mode,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       cur_mode,
   output logic       pll_reset,
   input  logic       pll_lock,
   output logic [1:0] mdopc,
   output logic       mdainc,
   output logic [7:0] mdwdi,
   input  logic [7:0] mdrdo
);

   localparam logic [2:0] LAST_IDX = 3'(NUM_ENTRIES - 1);

   state_e      state_q, state_d;
   logic        mode_q, mode_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  mirror_q, mirror_d;
   logic [1:0]  retry_q, retry_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        cur_mode_q, cur_mode_d;
   logic        pll_reset_q, pll_reset_d;
   logic [1:0]  mdopc_q, mdopc_d;
   logic        mdainc_q, mdainc_d;
   logic [7:0]  mdwdi_q, mdwdi_d;
   mdrp_entry_t cur_ent, nxt_ent, seq_ent;
   logic        run, rst_hit, to_hit;

   pll_mdrp_seq #(
      .RST_CYC      (RST_CYC),
      .LOCK_TIMEOUT (LOCK_TIMEOUT)
   ) u_seq (
      .clk     (mdclk),
      .reset   (reset),
      .run     (run),
      .rst_hit (rst_hit),
      .to_hit  (to_hit)
   );

   // Next state, then outputs decoded from the next state so they are registered
   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      idx_d      = idx_q;
      mirror_d   = mirror_q;
      retry_d    = retry_q;
      err_d      = err_q;
      cur_mode_d = cur_mode_q;
      cur_ent    = tbl_entry(mode_q, idx_q);
      seq_ent    = tbl_entry(mode_q, idx_q + 3'd1);
      case (state_q)
         IDLE: begin
            if (req) begin
               mode_d  = mode;
               err_d   = 1'b0;
               idx_d   = 3'd0;
               retry_d = 2'd0;
               state_d = PTR_RST;
            end
         end
         PTR_RST: begin
            mirror_d = 8'h00;
            if (rst_hit) begin
               idx_d   = 3'd0;
               state_d = SEEK;
            end
         end
         SEEK: begin
            if (mirror_q != cur_ent.addr) begin
               mirror_d = mirror_q + 8'd1;
            end else begin
               state_d = WRITE;
            end
         end
         WRITE:  state_d = READ;
         READ:   state_d = VERIFY;
         VERIFY: begin
            if (mdrdo == cur_ent.data) begin
               retry_d = 2'd0;
               state_d = NEXT;
            end else if (retry_q == 2'd2) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               retry_d = retry_q + 2'd1;
               state_d = WRITE;
            end
         end
         NEXT: begin
            if (idx_q == LAST_IDX) begin
               state_d = FIN_RST;
            end else begin
               idx_d   = idx_q + 3'd1;
               state_d = SEEK;
            end
         end
         FIN_RST: begin
            if (rst_hit) begin
               state_d = WAIT_LOCK;
            end
         end
         WAIT_LOCK: begin
            if (pll_lock) begin
               state_d = DONE;
            end else if (to_hit) begin
               err_d   = 1'b1;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      nxt_ent = tbl_entry(mode_d, idx_d);
      if (state_d == DONE && !err_d) begin
         cur_mode_d = mode_q;
      end
      busy_d      = (state_d != IDLE);
      done_d      = (state_d == DONE);
      pll_reset_d = (state_d == PTR_RST) || (state_d == FIN_RST);
      mdainc_d    = (state_d == SEEK) && (mirror_d != nxt_ent.addr);
      mdopc_d     = OPC_NOP;
      mdwdi_d     = 8'h00;
      if (state_d == WRITE) begin
         mdopc_d = OPC_WRITE;
         mdwdi_d = nxt_ent.data;
      end else if (state_d == READ) begin
         mdopc_d = OPC_READ;
      end
      run = (state_d == state_q) &&
            ((state_q == PTR_RST) || (state_q == FIN_RST) || (state_q == WAIT_LOCK));
   end

   // Controller state and registered outputs
   always_ff @(posedge mdclk) begin
      if (reset) begin
         state_q     <= IDLE;
         mode_q      <= 1'b0;
         idx_q       <= 3'd0;
         mirror_q    <= 8'h00;
         retry_q     <= 2'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         cur_mode_q  <= 1'b0;
         pll_reset_q <= 1'b0;
         mdopc_q     <= OPC_NOP;
         mdainc_q    <= 1'b0;
         mdwdi_q     <= 8'h00;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         idx_q       <= idx_d;
         mirror_q    <= mirror_d;
         retry_q     <= retry_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         cur_mode_q  <= cur_mode_d;
         pll_reset_q <= pll_reset_d;
         mdopc_q     <= mdopc_d;
         mdainc_q    <= mdainc_d;
         mdwdi_q     <= mdwdi_d;
      end
   end

   // A descending table address would make SEEK wrap the 8-bit pointer
   always_ff @(posedge mdclk) begin
      if (!reset && state_q == NEXT && idx_q != LAST_IDX) begin
         assert (seq_ent.addr > cur_ent.addr);
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign cur_mode  = cur_mode_q;
   assign pll_reset = pll_reset_q;
   assign mdopc     = mdopc_q;
   assign mdainc    = mdainc_q;
   assign mdwdi     = mdwdi_q;

endmodule

// File: doc/pll_mdrp_ctrl.md
PLL_MDRP_CTRL -- requirements
Module: pll_mdrp_ctrl

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 2, meaning register writes per mode table (1..8).
REQ-002 SHALL have parameter RST_CYC, default 4, meaning mdclk cycles pll_reset is held per pulse.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 65535, meaning mdclk cycles allowed for pll_lock after final reset.
REQ-004 SHALL have port mdclk, input, 1, sole clock; it also drives the PLL MDRP port.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port req, input, 1, start reconfiguration, sampled in IDLE only.
REQ-007 SHALL have port mode, input, 1, target table (0 = PAL, 1 = NTSC), sampled with req.
REQ-008 SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse) and err (output, 1, sticky until next accepted req).
REQ-009 SHALL have port cur_mode, output, 1, last successfully applied mode.
REQ-010 SHALL have port pll_reset, output, 1, PLL reset; it also zeroes the PLL MDRP address pointer.
REQ-011 SHALL have port pll_lock, input, 1, PLL lock indication, treated as synchronous to mdclk.
REQ-012 SHALL have ports mdopc (output, 2), mdainc (output, 1), mdwdi (output, 8) and mdrdo (input, 8), the MDRP bus. Opcodes: 00 NOP, 01 WRITE, 10 READ.

Function
REQ-013 SHALL implement states IDLE, PTR_RST, SEEK, WRITE, READ, VERIFY, NEXT, FIN_RST, WAIT_LOCK and DONE.
REQ-014 In IDLE with req=1, SHALL latch mode, clear err, set busy and enter PTR_RST the next cycle; req while busy SHALL be ignored.
REQ-015 PTR_RST: pll_reset=1 for exactly RST_CYC cycles; the local address mirror is cleared to 0; then go to SEEK at entry index 0.
REQ-016 SEEK: while mirror != entry address, pulse mdainc for one cycle and increment the mirror (8-bit) each cycle; on equality go to WRITE.
REQ-017 WRITE: mdopc=01 and mdwdi=entry data for exactly one cycle.
REQ-018 READ: mdopc=10 for one cycle; mdrdo is valid the following cycle (VERIFY).
REQ-019 VERIFY, match: go to NEXT. Mismatch: retry WRITE at most 2 times; on the third mismatch set err, pulse done and return to IDLE.
REQ-020 NEXT: if the index equals NUM_ENTRIES-1, go to FIN_RST; otherwise increment the index and go to SEEK.
REQ-021 FIN_RST: pll_reset=1 for RST_CYC cycles, then go to WAIT_LOCK with the timeout counter at 0.
REQ-022 WAIT_LOCK: on pll_lock=1 go to DONE; if the counter reaches LOCK_TIMEOUT, set err, pulse done and return to IDLE with cur_mode unchanged.
REQ-023 DONE: cur_mode takes the latched mode, done=1 for one cycle, busy=0 from the next cycle, and the state returns to IDLE.
REQ-024 When not in WRITE or READ, SHALL drive mdopc=00, mdwdi=00 and mdainc=0.
REQ-025 Table entry addresses within a mode SHALL be strictly ascending; a simulation assertion SHALL flag any violation.
REQ-026 A pll_lock drop outside WAIT_LOCK SHALL be ignored.

Reset
REQ-027 reset=1 SHALL force IDLE from any state, including mid-sequence, on the next edge.
REQ-028 Reset values SHALL be: busy=0, done=0, err=0, cur_mode=0, pll_reset=0, mdopc=00, mdainc=0, mdwdi=00, and all counters 0.

Structure
REQ-029 Package pll_mdrp_pkg SHALL hold the state enum, the MDRP opcode constants and the per-mode {addr, data} tables (PAL: MDIV/frac values for 141.8 MHz; NTSC: values for 143.2 MHz).
REQ-030 Sub-module pll_mdrp_seq SHALL be used, holding the shared reset-pulse and timeout counter; everything else stays in a single module.

Verification
REQ-031 req=1, mode=1, table {(0x05,0x35),(0x07,0x02)}, PLL model echoes writes and locks 100 cycles after reset -> 5 mdainc pulses, WRITE 0x35, READ, 2 further pulses, WRITE 0x02, done after lock, cur_mode=1, err=0.
REQ-032 Model returns 0x00 on every read -> exactly 3 WRITE cycles to the first address, then err=1, done pulse, cur_mode unchanged.
REQ-033 pll_lock held at 0 -> err=1 exactly LOCK_TIMEOUT cycles after FIN_RST ends; busy=0 the cycle after.
REQ-034 reset=1 asserted during SEEK -> next cycle state=IDLE, mdainc=0, pll_reset=0, busy=0.
REQ-035 req pulsed again while busy -> ignored; exactly one done pulse; the mode latched at the first req is applied.
